bip2_control: RTL and testbench

- Multicycle control unit for the BIP2 processor.
- Sits on the initiator side of the add/sub ALU: decodes each instruction, drives the ALU operation select and datapath muxes, and latches the ALU Z/N flags into a status register.
- Later conditional branches are resolved from that status register.
- Owns the PC and IR and sequences FETCH/EXEC, with a sticky HALT.

---
 rtl/bip2_control_if.sv | 32 +++
 rtl/bip2_control.sv | 137 +++++++++++++
 tb/tb_bip2_control.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bip2_control_if.sv
// Bus between the BIP2 control unit and its datapath: instruction fetch,
// ALU flags in, datapath/memory control strobes out.
interface bip2_control_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
);
  logic [DATA_WIDTH-1:0] instr_in;
  logic                  alu_Z_in;
  logic                  alu_N_in;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic [DATA_WIDTH-1:0] operand_out;
  logic [ADDR_WIDTH-1:0] data_addr_out;
  logic                  data_wr_out;
  logic                  acc_wr_out;
  logic [1:0]            acc_src_sel_out;
  logic                  alu_b_sel_out;
  logic                  alu_op_out;
  logic [1:0]            status_out;
  logic                  halted_out;

  modport master (
    input  instr_in, alu_Z_in, alu_N_in,
    output pc_out, operand_out, data_addr_out, data_wr_out, acc_wr_out,
           acc_src_sel_out, alu_b_sel_out, alu_op_out, status_out, halted_out
  );

  modport slave (
    output instr_in, alu_Z_in, alu_N_in,
    input  pc_out, operand_out, data_addr_out, data_wr_out, acc_wr_out,
           acc_src_sel_out, alu_b_sel_out, alu_op_out, status_out, halted_out
  );
endinterface

// File: rtl/bip2_control.sv
// BIP2 multicycle control unit: FETCH/EXEC sequencing, PC/IR ownership,
// {N,Z} status register and branch resolution, sticky HALT.
module bip2_control #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
) (
  input  logic             clock_in,
  input  logic             reset_n_in,
  bip2_control_if.master   bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_BGT  = 5'b01010;
  localparam logic [4:0] OP_BGE  = 5'b01011;
  localparam logic [4:0] OP_BLT  = 5'b01100;
  localparam logic [4:0] OP_BLE  = 5'b01101;
  localparam logic [4:0] OP_JMP  = 5'b01110;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [1:0]            status_q, status_d;

  logic [4:0]            opcode;
  logic signed [10:0]    imm;
  logic                  st_n, st_z;
  logic                  taken;
  logic                  data_wr, acc_wr, b_sel, alu_op;
  logic [1:0]            acc_src;

  assign opcode = ir_q[DATA_WIDTH-1 -: 5];
  assign imm    = ir_q[10:0];
  assign st_n   = status_q[1];
  assign st_z   = status_q[0];

  // Branches look only at the registered status, never at the live ALU flags.
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = st_z;
      OP_BNE:  taken = !st_z;
      OP_BGT:  taken = !st_z && !st_n;
      OP_BGE:  taken = !st_n;
      OP_BLT:  taken = st_n;
      OP_BLE:  taken = st_n || st_z;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    status_d = status_q;
    data_wr  = 1'b0;
    acc_wr   = 1'b0;
    acc_src  = 2'd0;
    b_sel    = 1'b0;
    alu_op   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = bus.instr_in;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = taken ? ir_q[ADDR_WIDTH-1:0] : pc_q + ADDR_WIDTH'(1);
        case (opcode)
          OP_HLT: begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          OP_STO: data_wr = 1'b1;
          OP_LD: begin
            acc_wr  = 1'b1;
            acc_src = 2'd1;
          end
          OP_LDI: begin
            acc_wr  = 1'b1;
            acc_src = 2'd2;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            acc_wr   = 1'b1;
            b_sel    = opcode[0];
            alu_op   = opcode[1];
            status_d = {bus.alu_N_in, bus.alu_Z_in};
          end
          default: ;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      status_q <= status_d;
    end
  end

  assign bus.pc_out          = pc_q;
  assign bus.operand_out     = {{(DATA_WIDTH-11){imm[10]}}, imm};
  assign bus.data_addr_out   = ir_q[ADDR_WIDTH-1:0];
  assign bus.data_wr_out     = data_wr;
  assign bus.acc_wr_out      = acc_wr;
  assign bus.acc_src_sel_out = acc_src;
  assign bus.alu_b_sel_out   = b_sel;
  assign bus.alu_op_out      = alu_op;
  assign bus.status_out      = status_q;
  assign bus.halted_out      = (state_q == S_HALT);

endmodule

// File: tb/tb_bip2_control.sv
// Directed bench for bip2_control: a table of instructions with hand-computed
// controls/PC/status, plus reset-abort and HALT sequences.
module tb_bip2_control;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        fz, fn;
  int          n_cmp;
  int          n_fail;

  bip2_control_if #(.DATA_WIDTH(16), .ADDR_WIDTH(11)) bus ();

  assign bus.instr_in = instr;
  assign bus.alu_Z_in = fz;
  assign bus.alu_N_in = fn;

  bip2_control #(.DATA_WIDTH(16), .ADDR_WIDTH(11)) dut (
    .clock_in   (clk),
    .reset_n_in (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic        z;
    logic        n;
    logic [5:0]  ctrl;     // {data_wr, acc_wr, acc_src[1:0], b_sel, alu_op} during EXEC
    logic [15:0] operand;
    logic [10:0] pc;       // PC after EXEC
    logic [1:0]  status;   // status after EXEC
  } vec_t;

  vec_t vecs[22];

  function automatic logic [5:0] ctrl_now();
    return {bus.data_wr_out, bus.acc_wr_out, bus.acc_src_sel_out,
            bus.alu_b_sel_out, bus.alu_op_out};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge while the DUT is in FETCH.
  task automatic run_instr(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    instr = v.instr;
    fz = v.z;
    fn = v.n;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".exec_ctrl"}, 32'(ctrl_now()), 32'(v.ctrl));
    chk({tag, ".operand"}, 32'(bus.operand_out), 32'(v.operand));
    chk({tag, ".exec_halted"}, 32'(bus.halted_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".pc"}, 32'(bus.pc_out), 32'(v.pc));
    chk({tag, ".status"}, 32'(bus.status_out), 32'(v.status));
    chk({tag, ".fetch_ctrl"}, 32'(ctrl_now()), 32'd0);
  endtask

  initial begin
    vec_t v;
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    instr  = 16'h0000;
    fz     = 1'b0;
    fn     = 1'b0;

    vecs[0]  = '{16'h1805, 1'b0, 1'b0, 6'b011000, 16'h0005, 11'h001, 2'b00}; // LDI 5
    vecs[1]  = '{16'h3805, 1'b1, 1'b0, 6'b010011, 16'h0005, 11'h002, 2'b01}; // SUBI 5, Z
    vecs[2]  = '{16'h4020, 1'b0, 1'b1, 6'b000000, 16'h0020, 11'h020, 2'b01}; // BEQ taken
    vecs[3]  = '{16'h2803, 1'b0, 1'b1, 6'b010010, 16'h0003, 11'h021, 2'b10}; // ADDI, N
    vecs[4]  = '{16'h5810, 1'b0, 1'b0, 6'b000000, 16'h0010, 11'h022, 2'b10}; // BGE not taken
    vecs[5]  = '{16'h6010, 1'b0, 1'b0, 6'b000000, 16'h0010, 11'h010, 2'b10}; // BLT taken
    vecs[6]  = '{16'h3007, 1'b0, 1'b0, 6'b010001, 16'h0007, 11'h011, 2'b00}; // SUB
    vecs[7]  = '{16'h1FFF, 1'b1, 1'b1, 6'b011000, 16'hFFFF, 11'h012, 2'b00}; // LDI -1
    vecs[8]  = '{16'h4830, 1'b1, 1'b0, 6'b000000, 16'h0030, 11'h030, 2'b00}; // BNE taken
    vecs[9]  = '{16'h1040, 1'b0, 1'b0, 6'b010100, 16'h0040, 11'h031, 2'b00}; // LD
    vecs[10] = '{16'h0841, 1'b1, 1'b1, 6'b100000, 16'h0041, 11'h032, 2'b00}; // STO
    vecs[11] = '{16'h2042, 1'b1, 1'b0, 6'b010000, 16'h0042, 11'h033, 2'b01}; // ADD, Z
    vecs[12] = '{16'h5050, 1'b0, 1'b0, 6'b000000, 16'h0050, 11'h034, 2'b01}; // BGT not taken
    vecs[13] = '{16'h6850, 1'b0, 1'b0, 6'b000000, 16'h0050, 11'h050, 2'b01}; // BLE taken
    vecs[14] = '{16'h77FF, 1'b0, 1'b0, 6'b000000, 16'hFFFF, 11'h7FF, 2'b01}; // JMP 0x7FF
    vecs[15] = '{16'hF800, 1'b0, 1'b1, 6'b000000, 16'h0000, 11'h000, 2'b01}; // NOP, wrap
    vecs[16] = '{16'h2000, 1'b0, 1'b0, 6'b010000, 16'h0000, 11'h001, 2'b00}; // ADD
    vecs[17] = '{16'h5060, 1'b1, 1'b1, 6'b000000, 16'h0060, 11'h060, 2'b00}; // BGT taken
    vecs[18] = '{16'h5870, 1'b0, 1'b1, 6'b000000, 16'h0070, 11'h070, 2'b00}; // BGE taken
    vecs[19] = '{16'h4010, 1'b1, 1'b0, 6'b000000, 16'h0010, 11'h071, 2'b00}; // BEQ not taken
    vecs[20] = '{16'h6810, 1'b1, 1'b1, 6'b000000, 16'h0010, 11'h072, 2'b00}; // BLE not taken
    vecs[21] = '{16'h6010, 1'b0, 1'b1, 6'b000000, 16'h0010, 11'h073, 2'b00}; // BLT not taken

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.pc", 32'(bus.pc_out), 32'd0);
    chk("rst.status", 32'(bus.status_out), 32'd0);
    chk("rst.ctrl", 32'(ctrl_now()), 32'd0);
    chk("rst.halted", 32'(bus.halted_out), 32'd0);
    chk("rst.operand", 32'(bus.operand_out), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) run_instr(vecs[i], i);

    // Reset asserted in the middle of STO's EXEC cycle
    instr = 16'h0841;
    @(posedge clk);
    @(negedge clk);
    chk("sto.data_wr", 32'(bus.data_wr_out), 32'd1);
    chk("sto.data_addr", 32'(bus.data_addr_out), 32'h041);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.data_wr", 32'(bus.data_wr_out), 32'd0);
    chk("abort.pc", 32'(bus.pc_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort.status", 32'(bus.status_out), 32'd0);
    chk("abort.ctrl", 32'(ctrl_now()), 32'd0);
    v = '{16'h1805, 1'b0, 1'b0, 6'b011000, 16'h0005, 11'h001, 2'b00};
    run_instr(v, 100);
    v = '{16'h2001, 1'b1, 1'b0, 6'b010000, 16'h0001, 11'h002, 2'b01};
    run_instr(v, 101);

    // HLT: PC held, then frozen against arbitrary instructions and flags
    v = '{16'h0000, 1'b0, 1'b1, 6'b000000, 16'h0000, 11'h002, 2'b01};
    run_instr(v, 102);
    chk("halt.halted", 32'(bus.halted_out), 32'd1);
    for (int k = 0; k < 10; k++) begin
      instr = 16'($urandom);
      fz = 1'($urandom);
      fn = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("halt%0d.pc", k), 32'(bus.pc_out), 32'h002);
      chk($sformatf("halt%0d.status", k), 32'(bus.status_out), 32'd1);
      chk($sformatf("halt%0d.ctrl", k), 32'(ctrl_now()), 32'd0);
      chk($sformatf("halt%0d.halted", k), 32'(bus.halted_out), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
